// File: rtl/me_fetch_ctrl.sv
// Read sequencer for the motion-estimation pixel memory: walks a BLK x BLK block, streams pixel pairs.
// Optional host write port on memory port A is enabled with `define ME_HOST_WRITE_EN.
module me_fetch_ctrl #(
    parameter int unsigned DWIDTH   = 8,
    parameter int unsigned AWIDTH   = 10,
    parameter int unsigned BLK      = 4,
    parameter int unsigned SW_WIDTH = 8,
    parameter int unsigned TPL_BASE = 0,
    parameter int unsigned SW_BASE  = 64
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_x,
    input  logic [3:0]        cmd_y,
    output logic [AWIDTH-1:0] address_a,
    output logic [AWIDTH-1:0] address_b,
    input  logic [DWIDTH-1:0] q_a,
    input  logic [DWIDTH-1:0] q_b,
    output logic              wren_a,
    output logic              wren_b,
    output logic [DWIDTH-1:0] data_a,
`ifdef ME_HOST_WRITE_EN
    input  logic              host_wr_valid,
    output logic              host_wr_ready,
    input  logic [AWIDTH-1:0] host_wr_addr,
    input  logic [DWIDTH-1:0] host_wr_data,
`endif
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic [DWIDTH-1:0] pix_tpl,
    output logic [DWIDTH-1:0] pix_sw,
    output logic              pix_last,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CW = (BLK > 1) ? $clog2(BLK) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     row_q, row_d, col_q, col_d;
    logic [3:0]        cx_q, cx_d, cy_q, cy_d;
    logic [AWIDTH-1:0] addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic [AWIDTH-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
    logic              pix_valid_q, pix_valid_d;
    logic              pix_last_q, pix_last_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              stall, cmd_acc, last_pos;

    function automatic logic [AWIDTH-1:0] tpl_addr(input logic [CW-1:0] r, input logic [CW-1:0] c);
        tpl_addr = AWIDTH'(TPL_BASE) + AWIDTH'(r) * AWIDTH'(BLK) + AWIDTH'(c);
    endfunction

    function automatic logic [AWIDTH-1:0] sw_addr(input logic [3:0] x, input logic [3:0] y,
                                                  input logic [CW-1:0] r, input logic [CW-1:0] c);
        sw_addr = AWIDTH'(SW_BASE) + (AWIDTH'(y) + AWIDTH'(r)) * AWIDTH'(SW_WIDTH)
                + AWIDTH'(x) + AWIDTH'(c);
    endfunction

    // While stalled the memory must re-read the pixel already on the output so q_a/q_b hold.
    always_comb begin
        stall     = pix_valid_q && !pix_ready;
        address_a = stall ? out_a_q : addr_a_q;
        address_b = stall ? out_b_q : addr_b_q;
        wren_a    = 1'b0;
        wren_b    = 1'b0;
        data_a    = '0;
        cmd_ready = cmd_ready_q;
        cmd_acc   = cmd_valid && (state_q == IDLE);
`ifdef ME_HOST_WRITE_EN
        host_wr_ready = cmd_ready_q;
        if (host_wr_valid && (state_q == IDLE)) begin
            address_a = host_wr_addr;
            data_a    = host_wr_data;
            wren_a    = 1'b1;
            cmd_ready = 1'b0;
            cmd_acc   = 1'b0;
        end
`endif
    end

    assign pix_valid = pix_valid_q;
    assign pix_last  = pix_last_q;
    assign pix_tpl   = q_a;
    assign pix_sw    = q_b;
    assign busy      = busy_q;
    assign done      = done_q;
    assign last_pos  = (row_q == CW'(BLK - 1)) && (col_q == CW'(BLK - 1));

    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        cx_d        = cx_q;
        cy_d        = cy_q;
        addr_a_d    = addr_a_q;
        addr_b_d    = addr_b_q;
        out_a_d     = out_a_q;
        out_b_d     = out_b_q;
        pix_valid_d = pix_valid_q;
        pix_last_d  = pix_last_q;
        cmd_ready_d = cmd_ready_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (cmd_acc) begin
                    cx_d        = cmd_x;
                    cy_d        = cmd_y;
                    row_d       = '0;
                    col_d       = '0;
                    addr_a_d    = tpl_addr('0, '0);
                    addr_b_d    = sw_addr(cmd_x, cmd_y, '0, '0);
                    state_d     = ISSUE;
                    cmd_ready_d = 1'b0;
                    busy_d      = 1'b1;
                end
            end
            ISSUE: begin
                // Presented address moves to the output stage; next pixel's address is loaded.
                if (!stall) begin
                    pix_valid_d = 1'b1;
                    out_a_d     = addr_a_q;
                    out_b_d     = addr_b_q;
                    pix_last_d  = last_pos;
                    if (last_pos) begin
                        state_d = DRAIN;
                    end else begin
                        if (col_q == CW'(BLK - 1)) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                        addr_a_d = tpl_addr(row_d, col_d);
                        addr_b_d = sw_addr(cx_q, cy_q, row_d, col_d);
                    end
                end
            end
            DRAIN: begin
                if (pix_ready) begin
                    pix_valid_d = 1'b0;
                    pix_last_d  = 1'b0;
                    done_d      = 1'b1;
                    state_d     = IDLE;
                    busy_d      = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            pix_valid_q <= 1'b0;
            pix_last_q  <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            cx_q        <= cx_d;
            cy_q        <= cy_d;
            addr_a_q    <= addr_a_d;
            addr_b_q    <= addr_b_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            pix_valid_q <= pix_valid_d;
            pix_last_q  <= pix_last_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

endmodule
